// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and defaults for the instruction fetch controller
package fetch_pkg;
  localparam int D_DEF = 12;
  localparam int W_DEF = 9;
  localparam int LUT_AW_DEF = 4;
  // All-ones opcode; signed so a width cast sign-extends to any instruction width
  localparam logic signed [W_DEF-1:0] HALT_OP = '1;
  typedef enum logic [2:0] {S_REQ, S_HOLD, S_ADV, S_REDIRECT, S_HALTED} state_t;
endpackage

// File: rtl/fetch_ctrl_jump_lut.sv
// jump_lut: programmable branch target table, sync write, async read-before-write
module jump_lut
  import fetch_pkg::*;
#(
  parameter int D  = D_DEF,
  parameter int AW = LUT_AW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [D-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [D-1:0]  o_rdata
);
  logic [D-1:0] r_mem [2**AW];
  // Clear the table on reset, otherwise accept writes in any controller state
  always_ff @(posedge clk) begin
    if (reset) for (int i = 0; i < 2**AW; i++) r_mem[i] <= '0;
    else if (i_we) r_mem[i_waddr] <= i_wdata;
  end
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetches instructions over req/ack, hands them to decode, steers the PC
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int D      = D_DEF,
  parameter int W      = W_DEF,
  parameter int LUT_AW = LUT_AW_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [D-1:0]      prog_ctr,
  output logic              next_flag,
  output logic              absjump_en,
  output logic [D-1:0]      target,
  output logic              imem_req,
  output logic [D-1:0]      imem_addr,
  input  logic              imem_ack,
  input  logic [W-1:0]      imem_data,
  output logic [W-1:0]      instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              br_taken,
  input  logic [LUT_AW-1:0] br_idx,
  input  logic              lut_we,
  input  logic [LUT_AW-1:0] lut_waddr,
  input  logic [D-1:0]      lut_wdata,
  output logic              halt
);
  state_t       r_state, w_next;
  logic [W-1:0] r_instr;
  logic [D-1:0] r_target;
  logic         r_pend;
  logic [D-1:0] w_lut_rdata;
  logic         w_redir;
  logic         w_is_halt;

  jump_lut #(.D(D), .AW(LUT_AW)) u_lut (
    .clk    (clk),
    .reset  (reset),
    .i_we   (lut_we),
    .i_waddr(lut_waddr),
    .i_wdata(lut_wdata),
    .i_raddr(br_idx),
    .o_rdata(w_lut_rdata)
  );

  // A branch seen while a request is outstanding stays pending until the ack arrives
  assign w_redir   = br_taken | r_pend;
  assign w_is_halt = r_instr == W'(HALT_OP);

  // Next-state decode plus Moore outputs from the current state
  always_comb begin
    w_next      = r_state;
    imem_req    = r_state == S_REQ;
    instr_valid = r_state == S_HOLD;
    next_flag   = r_state == S_ADV || r_state == S_REDIRECT;
    absjump_en  = r_state == S_REDIRECT;
    halt        = r_state == S_HALTED;
    imem_addr   = prog_ctr;
    instr       = r_instr;
    target      = r_target;
    unique case (r_state)
      S_REQ:      w_next = imem_ack ? (w_redir ? S_REDIRECT : S_HOLD) : S_REQ;
      S_HOLD:     w_next = (instr_ready && w_is_halt) ? S_HALTED :
                           br_taken ? S_REDIRECT : instr_ready ? S_ADV : S_HOLD;
      S_ADV:      w_next = br_taken ? S_REDIRECT : S_REQ;
      S_REDIRECT: w_next = br_taken ? S_REDIRECT : S_REQ;
      default:    w_next = S_HALTED;
    endcase
  end

  // State register, captured instruction, latched branch target and pending flag
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_REQ;
      r_instr  <= '0;
      r_target <= '0;
      r_pend   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_REQ && imem_ack && !w_redir) r_instr <= imem_data;
      if (br_taken && r_state != S_HALTED) r_target <= w_lut_rdata;
      r_pend <= r_state == S_REQ && !imem_ack && w_redir;
    end
  end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: scoreboard bench with a PC model and a latency-programmable memory
module tb_fetch_ctrl;
  logic        clk = 0;
  logic        reset = 1;
  logic [11:0] pc;
  logic        next_flag, absjump_en, imem_req, imem_ack, instr_valid, halt;
  logic [11:0] target, imem_addr, lut_wdata;
  logic [8:0]  imem_data, instr;
  logic        instr_ready = 0, br_taken = 0, lut_we = 0;
  logic [3:0]  br_idx = 0, lut_waddr = 0;
  logic        ack_en = 0, force_ack = 0;
  int          ack_dly = 0, ack_cnt;
  logic [8:0]  mem [4096];
  logic [8:0]  exp_q [$];
  logic [11:0] tgt_q [$];
  int          n_tests = 0, n_fail = 0, nf_cnt = 0, abs_cnt = 0;

  fetch_ctrl dut (
    .clk(clk), .reset(reset), .prog_ctr(pc), .next_flag(next_flag),
    .absjump_en(absjump_en), .target(target), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .br_taken(br_taken), .br_idx(br_idx), .lut_we(lut_we),
    .lut_waddr(lut_waddr), .lut_wdata(lut_wdata), .halt(halt)
  );

  always #5 clk = ~clk;

  assign imem_ack  = force_ack | (ack_en && imem_req && ack_cnt >= ack_dly);
  assign imem_data = mem[imem_addr];

  always @(posedge clk) begin
    if (reset) pc <= '0;
    else if (next_flag) pc <= absjump_en ? target : pc + 12'd1;
    if (reset || imem_ack) ack_cnt <= 0;
    else if (imem_req) ack_cnt <= ack_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) if (!reset) begin
    if (instr_valid && instr_ready) begin
      if (exp_q.size() != 0) check("instr", instr, exp_q.pop_front());
      else check("instr_expected", exp_q.size(), 1);
    end
    if (absjump_en) begin
      if (tgt_q.size() != 0) check("target", target, tgt_q.pop_front());
      else check("target_expected", tgt_q.size(), 1);
    end
    if (next_flag) nf_cnt++;
    if (absjump_en) abs_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1; br_taken = 0; lut_we = 0; force_ack = 0;
    tick(2);
    reset = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    // Sequential fetch
    mem[0] = 9'h001; mem[1] = 9'h002; mem[2] = 9'h003; mem[3] = 9'h004;
    ack_en = 1; ack_dly = 0; instr_ready = 1;
    tick(1);
    do_reset();
    @(negedge clk);
    check("rst_instr", instr, 0);
    check("rst_target", target, 0);
    check("rst_halt", halt, 0);
    check("rst_req", imem_req, 1);
    tick(0);
    exp_q.push_back(9'h001); exp_q.push_back(9'h002); exp_q.push_back(9'h003);
    nf_cnt = 0; abs_cnt = 0;
    tick(9);
    ack_en = 0;
    @(negedge clk);
    check("seq_pc", pc, 3);
    check("seq_addr", imem_addr, 3);
    check("seq_nf", nf_cnt, 3);
    check("seq_abs", abs_cnt, 0);
    // Branch while holding an unaccepted instruction, with a stray ack in REDIRECT
    mem[0] = 9'h0AA;
    ack_en = 1; instr_ready = 0;
    do_reset();
    lut_we = 1; lut_waddr = 5; lut_wdata = 12'h040;
    tick(1);
    lut_we = 0; br_taken = 1; br_idx = 5; tgt_q.push_back(12'h040);
    @(negedge clk);
    check("hold_valid", instr_valid, 1);
    tick(0);
    @(posedge clk); #1;
    br_taken = 0; ack_en = 0; force_ack = 1;
    @(negedge clk);
    check("hold_valid_drop", instr_valid, 0);
    check("hold_nf", next_flag, 1);
    check("hold_abs", absjump_en, 1);
    tick(0);
    @(posedge clk); #1;
    force_ack = 0;
    @(negedge clk);
    check("hold_addr", imem_addr, 12'h040);
    check("hold_req", imem_req, 1);
    check("stray_ack_valid", instr_valid, 0);
    // Branch during an outstanding request with a slow memory
    mem[0] = 9'h0BB; mem[12'h020] = 9'h055;
    ack_en = 1; ack_dly = 4; instr_ready = 1;
    do_reset();
    lut_we = 1; lut_waddr = 3; lut_wdata = 12'h020;
    tick(1);
    lut_we = 0; br_taken = 1; br_idx = 3; tgt_q.push_back(12'h020);
    tick(1);
    br_taken = 0;
    tick(2);
    @(negedge clk);
    check("late_ack", imem_ack, 1);
    check("late_valid", instr_valid, 0);
    tick(0);
    @(posedge clk); #1;
    ack_dly = 0; exp_q.push_back(9'h055);
    @(negedge clk);
    check("late_abs", absjump_en, 1);
    check("late_valid2", instr_valid, 0);
    tick(0);
    @(posedge clk); #1;
    @(negedge clk);
    check("late_addr", imem_addr, 12'h020);
    tick(0);
    @(posedge clk); #1;
    ack_en = 0;
    tick(2);
    // Same-cycle handshake and branch, with a colliding LUT write
    mem[0] = 9'h011;
    ack_en = 1; instr_ready = 0;
    do_reset();
    lut_we = 1; lut_waddr = 7; lut_wdata = 12'h030;
    tick(1);
    instr_ready = 1; br_taken = 1; br_idx = 7; lut_wdata = 12'h0FF;
    exp_q.push_back(9'h011); tgt_q.push_back(12'h030);
    nf_cnt = 0; abs_cnt = 0;
    tick(1);
    lut_we = 0; br_taken = 0; ack_en = 0;
    tick(1);
    @(negedge clk);
    check("same_nf", nf_cnt, 1);
    check("same_abs", abs_cnt, 1);
    check("same_addr", imem_addr, 12'h030);
    check("same_pc", pc, 12'h030);
    // Reset while waiting on a slow ack
    tick(0);
    @(posedge clk); #1;
    ack_en = 1; ack_dly = 5;
    tick(2);
    reset = 1;
    tick(1);
    reset = 0;
    @(negedge clk);
    check("mid_instr", instr, 0);
    check("mid_target", target, 0);
    check("mid_valid", instr_valid, 0);
    check("mid_nf", next_flag, 0);
    check("mid_req", imem_req, 1);
    check("mid_addr", imem_addr, 0);
    tick(0);
    @(posedge clk); #1;
    ack_en = 0; ack_dly = 0; mem[0] = 9'h033; exp_q.push_back(9'h033);
    ack_en = 1;
    tick(2);
    ack_en = 0;
    tick(2);
    // HALT opcode stops fetching until reset
    mem[0] = 9'h001; mem[1] = 9'h002; mem[2] = 9'h1FF;
    ack_en = 1; instr_ready = 1;
    do_reset();
    exp_q.push_back(9'h001); exp_q.push_back(9'h002); exp_q.push_back(9'h1FF);
    tick(8);
    @(negedge clk);
    check("halt_set", halt, 1);
    check("halt_req", imem_req, 0);
    check("halt_pc", pc, 2);
    tick(0);
    lut_we = 1; lut_waddr = 2; lut_wdata = 12'h077;
    tick(1);
    lut_we = 0; br_taken = 1; br_idx = 2; force_ack = 1;
    tick(1);
    br_taken = 0; force_ack = 0; ack_en = 0;
    tick(2);
    @(negedge clk);
    check("halt_target", target, 0);
    check("halt_hold", halt, 1);
    check("halt_req2", imem_req, 0);
    check("halt_nf", next_flag, 0);
    check("halt_instr", instr, 9'h1FF);
    tick(0);
    do_reset();
    @(negedge clk);
    check("unhalt", halt, 0);
    check("unhalt_req", imem_req, 1);
    check("unhalt_addr", imem_addr, 0);
    tick(2);
    check("exp_q_empty", exp_q.size(), 0);
    check("tgt_q_empty", tgt_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
